// File: rtl/serial_alu.sv
// serial_alu: two-beat serial-opcode 8-bit ALU (add/sub/xor/xnor); ALU_OP_TIMEOUT_EN adds a GOT_A idle timeout with timeout_err.
module serial_alu #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
`ifdef ALU_OP_TIMEOUT_EN
  output logic                  timeout_err,
`endif
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, GOT_A, EXEC, DONE} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] a, b;
  logic [1:0] op;
  logic [DATA_WIDTH:0] calc;
`ifdef ALU_OP_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] cnt;
`endif
  // Zero-extended subtract leaves the borrow in the top bit.
  always_comb
    calc = op == 2'b00 ? {1'b0, a} + {1'b0, b} :
           op == 2'b01 ? {1'b0, a} - {1'b0, b} :
           op == 2'b10 ? {1'b0, a ^ b} : {1'b0, ~(a ^ b)};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      op <= '0;
      result <= '0;
      overflow <= 1'b0;
      done <= 1'b0;
`ifdef ALU_OP_TIMEOUT_EN
      cnt <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      done <= state == DONE;
`ifdef ALU_OP_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE, DONE: begin
          if (opcode_valid) begin
            a <= data;
            op[0] <= opcode;
            state <= GOT_A;
`ifdef ALU_OP_TIMEOUT_EN
            cnt <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GOT_A: begin
          if (opcode_valid) begin
            b <= data;
            op[1] <= opcode;
            state <= EXEC;
          end
`ifdef ALU_OP_TIMEOUT_EN
          else if (int'(cnt) == TIMEOUT - 1) begin
            timeout_err <= 1'b1;
            a <= '0;
            op[0] <= 1'b0;
            cnt <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        EXEC: begin
          {overflow, result} <= calc;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
